median_feeder: RTL and testbench

// Initiator side of the MEDIAN streaming interface (DI/DSI in, DO/DSO back).
// - Collects N samples from an upstream valid/ready source into a local buffer.
// - Replays them to MEDIAN as one contiguous DSI burst, then waits for DSO.
// - Captures DO and offers it downstream on a valid/ready port.
// - Guarantees the gap-free N-cycle DSI burst that MEDIAN requires, whatever upstream stalls occur.

---
 rtl/median_feeder.sv | 122 ++++++++++++
 tb/tb_median_feeder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/median_feeder.sv
// Initiator for the MEDIAN DI/DSI -> DO/DSO interface: buffers one window from a
// valid/ready source, replays it as a gap-free DSI burst, and returns the result downstream.
module median_feeder #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned N       = 9,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] DI,
    output logic             DSI,
    input  logic [WIDTH-1:0] DO,
    input  logic             DSO,
    output logic [WIDTH-1:0] RES,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             ERR
);
    localparam int unsigned   CW       = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned   TW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {LOAD, SEND, WAIT, HOLD} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [TW-1:0]    tmo, tmo_nxt;
    logic [WIDTH-1:0] samples [N];
    logic [WIDTH-1:0] di_nxt, res_nxt;
    logic             dsi_nxt, ov_nxt, err_nxt;
    logic             in_xfer;

    assign IN_READY = (state == LOAD);
    assign in_xfer  = IN_VALID && IN_READY;

    // Sample storage needs no reset: a reset always restarts collection at index 0.
    always_ff @(posedge CLK) begin
        if (in_xfer) samples[cnt] <= IN_DATA;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tmo_nxt   = tmo;
        di_nxt    = '0;
        dsi_nxt   = 1'b0;
        res_nxt   = RES;
        ov_nxt    = OUT_VALID;
        err_nxt   = 1'b0;
        case (state)
            LOAD: begin
                if (in_xfer) begin
                    if (cnt == CNT_LAST) begin
                        // DI/DSI are registered, so the first beat is launched on the last load edge.
                        cnt_nxt   = '0;
                        state_nxt = SEND;
                        dsi_nxt   = 1'b1;
                        di_nxt    = (N == 1) ? IN_DATA : samples[0];
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            SEND: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    tmo_nxt   = '0;
                    state_nxt = WAIT;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    dsi_nxt = 1'b1;
                    di_nxt  = samples[cnt_nxt];
                end
            end
            WAIT: begin
                if (DSO) begin
                    res_nxt   = DO;
                    ov_nxt    = 1'b1;
                    state_nxt = HOLD;
                end else if (tmo == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = LOAD;
                end else begin
                    tmo_nxt = tmo + TW'(1);
                end
            end
            HOLD: begin
                if (OUT_READY) begin
                    ov_nxt    = 1'b0;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= LOAD;
            cnt       <= '0;
            tmo       <= '0;
            DI        <= '0;
            DSI       <= 1'b0;
            RES       <= '0;
            OUT_VALID <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tmo       <= tmo_nxt;
            DI        <= di_nxt;
            DSI       <= dsi_nxt;
            RES       <= res_nxt;
            OUT_VALID <= ov_nxt;
            ERR       <= err_nxt;
        end
    end
endmodule

// File: tb/tb_median_feeder.sv
// Randomized self-checking bench for median_feeder with a behavioural MEDIAN responder.
module tb_median_feeder;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned N       = 9;
    localparam int unsigned TIMEOUT = 64;

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic [WIDTH-1:0] IN_DATA = '0;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [WIDTH-1:0] DI;
    logic             DSI;
    logic [WIDTH-1:0] DO = '0;
    logic             DSO = 1'b0;
    logic [WIDTH-1:0] RES;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic             ERR;

    always #5 CLK = ~CLK;

    median_feeder #(.WIDTH(WIDTH), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .DI(DI), .DSI(DSI), .DO(DO), .DSO(DSO),
        .RES(RES), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .ERR(ERR)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [WIDTH-1:0] win_q[$];
    logic [WIDTH-1:0] burst_q[$];
    logic [WIDTH-1:0] fixed_w [9] = '{8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6};
    int  runs_q[$];
    int  run_len = 0, cd = 0, err_cnt = 0, err_cyc = 0, fall_cyc = 0, last_res = 0;
    bit  prev_dsi = 1'b0, resp_en = 1'b1, spur_send = 1'b0, spur_hold = 1'b0, spur_h_done = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int median_of(input logic [WIDTH-1:0] q[$]);
        logic [WIDTH-1:0] t[$];
        t = q;
        t.sort();
        if (t.size() == 0) return 0;
        return int'(t[t.size() / 2]);
    endfunction

    // MEDIAN model and burst monitor: records every DSI run, answers 3 cycles after it ends.
    initial forever begin
        @(negedge CLK);
        DSO = 1'b0;
        DO  = '0;
        if (DSI) begin
            burst_q.push_back(DI);
            run_len++;
        end else if (prev_dsi) begin
            runs_q.push_back(run_len);
            run_len  = 0;
            fall_cyc = cyc;
            cd       = 3;
        end
        if (ERR) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0 && resp_en) begin
                DSO = 1'b1;
                DO  = WIDTH'(median_of(burst_q));
            end
        end
        if (spur_send && DSI && run_len == 3) begin
            DSO = 1'b1;
            DO  = 8'hEE;
        end
        if (spur_hold && OUT_VALID && !spur_h_done) begin
            DSO = 1'b1;
            DO  = 8'hAA;
            spur_h_done = 1'b1;
        end
        prev_dsi = DSI;
    end

    task automatic clear_mon();
        burst_q.delete();
        runs_q.delete();
        run_len     = 0;
        err_cnt     = 0;
        cd          = 0;
        spur_h_done = 1'b0;
    endtask

    task automatic make_window(input bit fixed);
        win_q.delete();
        for (int i = 0; i < N; i++)
            win_q.push_back(fixed ? fixed_w[i] : WIDTH'($urandom_range(0, 255)));
    endtask

    task automatic feed(input bit gap);
        foreach (win_q[i]) begin
            if (gap) begin
                IN_VALID = 1'b0;
                @(negedge CLK);
            end
            check("dsi_idle", int'(DSI), 0);
            check("in_ready", int'(IN_READY), 1);
            IN_DATA  = win_q[i];
            IN_VALID = 1'b1;
            @(negedge CLK);
        end
        IN_VALID = 1'b0;
        IN_DATA  = '0;
        check("dsi_first", int'(DSI), 1);
    endtask

    task automatic run_window(input bit fixed, input bit gap, input int hold);
        int exp_res;
        int w;
        clear_mon();
        make_window(fixed);
        feed(gap);
        w = 0;
        while (!OUT_VALID && w < 200) begin
            @(negedge CLK);
            w++;
        end
        check("ov_wait", int'(OUT_VALID), 1);
        exp_res = median_of(win_q);
        check("burst_runs", runs_q.size(), 1);
        if (runs_q.size() > 0) check("burst_len", runs_q[0], N);
        check("burst_cnt", burst_q.size(), N);
        for (int i = 0; i < N && i < burst_q.size(); i++)
            check("burst_di", int'(burst_q[i]), int'(win_q[i]));
        check("res", int'(RES), exp_res);
        if (fixed) check("res_fixed", int'(RES), 5);
        check("no_err", err_cnt, 0);
        for (int i = 0; i < hold; i++) begin
            check("hold_ov", int'(OUT_VALID), 1);
            check("hold_inrdy", int'(IN_READY), 0);
            check("hold_res", int'(RES), exp_res);
            @(negedge CLK);
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        check("ov_drop", int'(OUT_VALID), 0);
        check("inrdy_back", int'(IN_READY), 1);
        last_res = exp_res;
    endtask

    initial begin
        int w;
        #2;
        check("rst_inrdy", int'(IN_READY), 1);
        check("rst_dsi", int'(DSI), 0);
        check("rst_di", int'(DI), 0);
        check("rst_res", int'(RES), 0);
        check("rst_ov", int'(OUT_VALID), 0);
        check("rst_err", int'(ERR), 0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // Fixed window: back-to-back, with input gaps, with long output backpressure.
        run_window(1'b1, 1'b0, 0);
        run_window(1'b1, 1'b1, 0);
        run_window(1'b1, 1'b0, 10);

        // MEDIAN never answers: timeout abort.
        clear_mon();
        resp_en = 1'b0;
        make_window(1'b0);
        feed(1'b0);
        w = 0;
        while (err_cnt == 0 && w < 200) begin
            @(negedge CLK);
            w++;
        end
        check("err_seen", err_cnt, 1);
        check("err_delay", err_cyc - fall_cyc, TIMEOUT);
        check("to_ov", int'(OUT_VALID), 0);
        check("to_inrdy", int'(IN_READY), 1);
        check("to_res", int'(RES), last_res);
        repeat (3) @(negedge CLK);
        check("err_once", err_cnt, 1);
        check("err_low", int'(ERR), 0);
        check("to_ov2", int'(OUT_VALID), 0);
        resp_en = 1'b1;

        // Reset during the 4th burst cycle, then a full fresh window.
        clear_mon();
        resp_en = 1'b0;
        make_window(1'b0);
        feed(1'b0);
        repeat (3) @(negedge CLK);
        check("dsi_pre_rst", int'(DSI), 1);
        nRST = 1'b0;
        #1;
        check("rst_mid_dsi", int'(DSI), 0);
        check("rst_mid_di", int'(DI), 0);
        check("rst_mid_inrdy", int'(IN_READY), 1);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (5) @(negedge CLK);
        resp_en  = 1'b1;
        last_res = 0;
        run_window(1'b0, 1'b0, 0);

        // Spurious DSO during SEND and HOLD.
        spur_send = 1'b1;
        spur_hold = 1'b1;
        run_window(1'b0, 1'b0, 3);
        spur_send = 1'b0;
        spur_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("spur_no_ov", int'(OUT_VALID), 0);
            check("spur_res", int'(RES), last_res);
            @(negedge CLK);
        end

        // Random windows with random gaps and backpressure.
        repeat (4) run_window(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
